// File: rtl/hex_scan_ctrl_pkg.sv
// hex_scan_ctrl_pkg: shared 7-segment encodings, hex digit type and decode helper.
package hex_scan_ctrl_pkg;

    typedef logic [3:0] hex_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit order g..a
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] decode_hex(input hex_digit_t digit);
        return SEG_GLYPH[digit];
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational hex nibble to active-low 7-segment glyph.
module hex_seg_decode
    import hex_scan_ctrl_pkg::*;
(
    input  hex_digit_t  digit,
    output logic [6:0]  seg
);

    assign seg = decode_hex(digit);

endmodule

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: scans NDIG common-anode digits through one shared decoder,
// double-buffering the display word so updates land only on frame boundaries.
module hex_scan_ctrl
    import hex_scan_ctrl_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int DIV  = 50000,
    parameter int GAP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [4*NDIG-1:0] load_data,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic              frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);

    logic [4*NDIG-1:0] shadow_word, active_word;
    logic [NDIG-1:0]   shadow_dp, active_dp;
    logic              pending;
    logic [CW-1:0]     div_cnt;
    logic [IW-1:0]     idx;
    logic              div_wrap, boundary, accept, lz;
    hex_digit_t        nib;
    logic [6:0]        glyph;

    assign load_ready = !pending;
    assign accept     = load_valid && !pending;
    assign div_wrap   = div_cnt == CW'(DIV - 1);
    assign boundary   = div_wrap && idx == IW'(NDIG - 1);
    assign nib        = active_word[{idx, 2'b00} +: 4];
    // Blank a non-zero digit position when it and every digit above it are zero
    assign lz         = blank_lz && idx != '0 && (active_word >> {idx, 2'b00}) == '0;

    hex_seg_decode u_dec (
        .digit (nib),
        .seg   (glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_word <= '0;
            shadow_dp   <= '0;
            active_word <= '0;
            active_dp   <= '0;
            pending     <= 1'b0;
            div_cnt     <= '0;
            idx         <= '0;
            an          <= '1;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            div_cnt    <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap)
                idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
            frame_tick <= boundary;
            // accept implies !pending, so a same-cycle boundary never commits the new word
            if (accept) begin
                shadow_word <= load_data;
                shadow_dp   <= dp_in;
                pending     <= 1'b1;
            end else if (boundary && pending) begin
                active_word <= shadow_word;
                active_dp   <= shadow_dp;
                pending     <= 1'b0;
            end
            if (div_cnt < CW'(GAP)) begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= ~(NDIG'(1) << idx);
                seg <= lz ? SEG_BLANK : glyph;
                dp  <= ~active_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: table-driven check of hex_scan_ctrl with NDIG=4, DIV=4, GAP=1,
// plus directed sequences for boundary accept, blocked reload and mid-slot reset.
module tb_hex_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    logic [6:0] cap_seg [4];
    logic       cap_dp  [4];

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dpm;
        logic            blank;
        logic [3:0][6:0] eseg;
        logic [3:0]      edp;
    } vec_t;

    vec_t vecs [8];

    hex_scan_ctrl #(.NDIG(4), .DIV(4), .GAP(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_tick && n < 40);
        check({name, " frame_tick"}, 32'(frame_tick), 32'd1);
    endtask

    task automatic capture_frame(input string name);
        int bad;
        logic [3:0] seen;
        logic hit;
        bad = 0;
        seen = '0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (an == 4'hF) begin
                if (seg !== 7'h7F || dp !== 1'b1) bad++;
            end else begin
                hit = 1'b0;
                for (int i = 0; i < 4; i++)
                    if (an == ~(4'b0001 << i)) begin
                        cap_seg[i] = seg;
                        cap_dp[i]  = dp;
                        seen[i]    = 1'b1;
                        hit        = 1'b1;
                    end
                if (!hit) bad++;
            end
        end
        if (seen != 4'hF) bad++;
        check({name, " scan"}, 32'(bad), 32'd0);
    endtask

    task automatic check_frame(input string name, input logic [3:0][6:0] es, input logic [3:0] ed);
        capture_frame(name);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s seg%0d", name, i), 32'(cap_seg[i]), 32'(es[i]));
            check($sformatf("%s dp%0d", name, i), 32'(cap_dp[i]), 32'(ed[i]));
        end
    endtask

    task automatic load(input logic [15:0] data, input logic [3:0] dpm);
        load_data  = data;
        dp_in      = dpm;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h12AF, 4'b0100, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011};
        vecs[1] = '{16'h0030, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[3] = '{16'h0000, 4'b1110, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001};
        vecs[4] = '{16'h8C5E, 4'b0001, 1'b1, {7'h00, 7'h46, 7'h12, 7'h06}, 4'b1110};
        vecs[5] = '{16'h0907, 4'b0000, 1'b1, {7'h7F, 7'h10, 7'h40, 7'h78}, 4'b1111};
        vecs[6] = '{16'h0907, 4'b0000, 1'b0, {7'h40, 7'h10, 7'h40, 7'h78}, 4'b1111};
        vecs[7] = '{16'h6D3B, 4'b1000, 1'b0, {7'h02, 7'h21, 7'h30, 7'h03}, 4'b0111};

        repeat (2) @(posedge clk);
        #1;
        check("rst an", 32'(an), 32'hF);
        check("rst seg", 32'(seg), 32'h7F);
        check("rst dp", 32'(dp), 32'd1);
        check("rst load_ready", 32'(load_ready), 32'd1);
        check("rst frame_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        check_frame("first", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
        check("first boundary tick", 32'(frame_tick), 32'd1);

        for (int k = 0; k < 8; k++) begin
            blank_lz = vecs[k].blank;
            load(vecs[k].data, vecs[k].dpm);
            check($sformatf("v%0d ready low", k), 32'(load_ready), 32'd0);
            wait_frame($sformatf("v%0d", k));
            check($sformatf("v%0d ready high", k), 32'(load_ready), 32'd1);
            check_frame($sformatf("v%0d", k), vecs[k].eseg, vecs[k].edp);
        end

        // Accept lands exactly on the boundary cycle: old word must persist one frame
        wait_frame("bnd sync");
        repeat (15) tick();
        load(16'h1111, 4'b0000);
        check("bnd tick1", 32'(frame_tick), 32'd1);
        check("bnd ready low", 32'(load_ready), 32'd0);
        check_frame("bnd old", {7'h02, 7'h21, 7'h30, 7'h03}, 4'b0111);
        check("bnd tick2", 32'(frame_tick), 32'd1);
        check("bnd ready high", 32'(load_ready), 32'd1);
        check_frame("bnd new", {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1111);

        // Second offer while pending must be ignored
        wait_frame("pend sync");
        load(16'h2222, 4'b0000);
        load_data  = 16'h3333;
        dp_in      = 4'b1111;
        load_valid = 1'b1;
        repeat (5) tick();
        check("pend ready low", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        wait_frame("pend");
        check("pend ready high", 32'(load_ready), 32'd1);
        check_frame("pend", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);
        check("pend no reaccept", 32'(load_ready), 32'd1);

        // Reset mid-slot with a commit pending
        load(16'h5555, 4'b1111);
        repeat (6) tick();
        check("mid lit", 32'(an), 32'hD);
        rst_n = 1'b0;
        #1;
        check("mid rst an", 32'(an), 32'hF);
        check("mid rst seg", 32'(seg), 32'h7F);
        check("mid rst dp", 32'(dp), 32'd1);
        check("mid rst ready", 32'(load_ready), 32'd1);
        check("mid rst tick", 32'(frame_tick), 32'd0);
        #2;
        rst_n = 1'b1;
        check_frame("post rst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
        check_frame("post rst2", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
